// File: rtl/pool1_max_if.sv
// Stream bundle for the 2x2 pooling stage: conv1 samples in, pooled samples out.
// The master drives the input samples; the pooling stage is the slave.
interface pool1_max_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] pool_data_in;
   logic              pool_data_in_valid;
   logic [DATA_W-1:0] pool_data_out;
   logic              pool_data_out_valid;
   logic              frame_done;

   modport master (
      output pool_data_in,
      output pool_data_in_valid,
      input  pool_data_out,
      input  pool_data_out_valid,
      input  frame_done
   );

   modport slave (
      input  pool_data_in,
      input  pool_data_in_valid,
      output pool_data_out,
      output pool_data_out_valid,
      output frame_done
   );
endinterface

// File: rtl/pool1_max.sv
// 2x2 stride-2 pooling of a raster-order IN_WIDTH x IN_WIDTH stream (max by default).
// Define POOL1_AVG_EN to build the truncating average-pooling variant instead.
module pool1_max #(
   parameter int IN_WIDTH = 23,
   parameter int DATA_W   = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   pool1_max_if.slave pool_if
);
   localparam int OUT_WIDTH = IN_WIDTH / 2;
   localparam int CNT_W     = $clog2(IN_WIDTH + 1);
   localparam int IDX_W     = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
   localparam int OCNT_W    = $clog2(OUT_WIDTH * OUT_WIDTH + 1);
   localparam logic [CNT_W-1:0]  ACT_LIM  = CNT_W'(2 * OUT_WIDTH);
   localparam logic [CNT_W-1:0]  POS_LAST = CNT_W'(IN_WIDTH - 1);
   localparam logic [OCNT_W-1:0] OUT_LAST = OCNT_W'(OUT_WIDTH * OUT_WIDTH - 1);
`ifdef POOL1_AVG_EN
   localparam int LB_W = DATA_W + 1;
`else
   localparam int LB_W = DATA_W;
`endif

   logic [CNT_W-1:0]  col_cnt_reg;
   logic [CNT_W-1:0]  row_cnt_reg;
   logic [OCNT_W-1:0] out_cnt_reg;
   logic [DATA_W-1:0] h_reg;
   logic [LB_W-1:0]   lbuf [OUT_WIDTH];
   logic [DATA_W-1:0] data_out_reg;
   logic              valid_out_reg;
   logic              frame_done_reg;

   logic              in_valid;
   logic              active;
   logic              even_col;
   logic              odd_row;
   logic              lb_wr;
   logic              out_fire;
   logic [IDX_W-1:0]  lb_idx;
   logic [LB_W-1:0]   lb_rd;
   logic [LB_W-1:0]   h_val;
   logic [DATA_W-1:0] pooled;
`ifdef POOL1_AVG_EN
   logic [DATA_W+1:0] win_sum;
`endif

   // Trailing row/column of an odd-sized map fall outside every window.
   assign in_valid = pool_if.pool_data_in_valid;
   assign active   = in_valid && (col_cnt_reg < ACT_LIM) && (row_cnt_reg < ACT_LIM);
   assign even_col = ~col_cnt_reg[0];
   assign odd_row  = row_cnt_reg[0];
   assign lb_wr    = active && !even_col && !odd_row;
   assign out_fire = active && !even_col && odd_row;
   assign lb_idx   = IDX_W'(col_cnt_reg >> 1);
   assign lb_rd    = lbuf[lb_idx];

   always_comb begin
      h_val  = '0;
      pooled = '0;
`ifdef POOL1_AVG_EN
      // Sums are carried wide so an all-ones window cannot overflow.
      win_sum = '0;
      h_val   = {1'b0, h_reg} + {1'b0, pool_if.pool_data_in};
      win_sum = {1'b0, lb_rd} + {1'b0, h_val};
      pooled  = DATA_W'(win_sum >> 2);
`else
      h_val  = (pool_if.pool_data_in > h_reg) ? pool_if.pool_data_in : h_reg;
      pooled = (lb_rd > h_val) ? lb_rd : h_val;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt_reg    <= '0;
         row_cnt_reg    <= '0;
         out_cnt_reg    <= '0;
         h_reg          <= '0;
         data_out_reg   <= '0;
         valid_out_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         valid_out_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
         if (in_valid) begin
            if (col_cnt_reg == POS_LAST) begin
               col_cnt_reg <= '0;
               row_cnt_reg <= (row_cnt_reg == POS_LAST) ? '0 : row_cnt_reg + CNT_W'(1);
            end else begin
               col_cnt_reg <= col_cnt_reg + CNT_W'(1);
            end
         end
         if (active && even_col) begin
            h_reg <= pool_if.pool_data_in;
         end
         if (out_fire) begin
            data_out_reg  <= pooled;
            valid_out_reg <= 1'b1;
            if (out_cnt_reg == OUT_LAST) begin
               out_cnt_reg    <= '0;
               frame_done_reg <= 1'b1;
            end else begin
               out_cnt_reg <= out_cnt_reg + OCNT_W'(1);
            end
         end
      end
   end

   // Line buffer contents are always written before being read, so no reset.
   always_ff @(posedge clk) begin
      if (lb_wr) begin
         lbuf[lb_idx] <= h_val;
      end
   end

   assign pool_if.pool_data_out       = data_out_reg;
   assign pool_if.pool_data_out_valid = valid_out_reg;
   assign pool_if.frame_done          = frame_done_reg;
endmodule

// File: tb/tb_pool1_max.sv
// Randomized self-checking bench for pool1_max against a window-level reference model.
// Builds with or without POOL1_AVG_EN; the model follows the same macro.
module tb_pool1_max;
   localparam int IW   = 23;
   localparam int OW   = IW / 2;
   localparam int NOUT = OW * OW;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pool1_max_if #(.DATA_W(32)) pif ();

   pool1_max #(
      .IN_WIDTH (IW),
      .DATA_W   (32)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .pool_if (pif.slave)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] img [IW][IW];
   logic [31:0] exp_q [$];
   logic [31:0] last_out;
   bit          pend;
   int          out_idx;
   int          fd_cnt;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, expv);
      end
   endtask

   // Reference: each output is a reduction over its own 2x2 window of the image.
   function automatic logic [31:0] window_ref(input int r, input int c);
      logic [31:0] a, b, d, e;
      logic [33:0] s;
      logic [31:0] m;
      a = img[2*r][2*c];
      b = img[2*r][2*c+1];
      d = img[2*r+1][2*c];
      e = img[2*r+1][2*c+1];
      s = 34'(a) + 34'(b) + 34'(d) + 34'(e);
      m = a;
      if (b > m) m = b;
      if (d > m) m = d;
      if (e > m) m = e;
`ifdef POOL1_AVG_EN
      return s[33:2];
`else
      if (s == 34'h0) m = 32'h0;
      return m;
`endif
   endfunction

   task automatic build_expected();
      for (int r = 0; r < OW; r++)
         for (int c = 0; c < OW; c++)
            exp_q.push_back(window_ref(r, c));
   endtask

   task automatic check_outputs();
      logic [31:0] e;
      if (pend) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         check("out_valid", 64'(pif.pool_data_out_valid), 64'(1));
         check("out_data", 64'(pif.pool_data_out), 64'(e));
         check("frame_done_last", 64'(pif.frame_done), 64'(out_idx == NOUT - 1));
         out_idx  = (out_idx == NOUT - 1) ? 0 : out_idx + 1;
         last_out = e;
      end else begin
         check("idle_valid", 64'(pif.pool_data_out_valid), 64'(0));
         check("idle_frame_done", 64'(pif.frame_done), 64'(0));
         check("hold_data", 64'(pif.pool_data_out), 64'(last_out));
      end
      if (pif.frame_done === 1'b1) fd_cnt++;
   endtask

   task automatic step(input logic v, input logic [31:0] d, input bit br);
      @(negedge clk);
      check_outputs();
      pif.pool_data_in_valid = v;
      pif.pool_data_in       = d;
      pend                   = br;
   endtask

   task automatic send_frame(input int max_gap, input int n_samples);
      for (int i = 0; i < n_samples; i++) begin
         int r, c, g;
         r = i / IW;
         c = i % IW;
         g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int k = 0; k < g; k++) step(1'b0, $urandom, 1'b0);
         step(1'b1, img[r][c], (r % 2 == 1) && (c % 2 == 1) && (r < 2*OW) && (c < 2*OW));
      end
   endtask

   task automatic flush();
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      check("queue_drained", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic fill(input int kind);
      for (int r = 0; r < IW; r++)
         for (int c = 0; c < IW; c++)
            case (kind)
               0: img[r][c] = 32'(r * IW + c);
               1: img[r][c] = (r == 3 && c == 4) ? 32'd1000 : 32'd0;
               2: img[r][c] = (r == IW - 1 || c == IW - 1) ? 32'hFFFF_FFFF : 32'd0;
               3: img[r][c] = $urandom;
               4: img[r][c] = 32'(1 + 2 * (r % 2) + (c % 2));
               default: img[r][c] = 32'hFFFF_FFFF;
            endcase
   endtask

   task automatic run_frame(input string name, input int kind, input int max_gap);
      int c0, e0;
      c0 = checks;
      e0 = errors;
      fill(kind);
      build_expected();
      send_frame(max_gap, IW * IW);
      flush();
      $display("frame %s checks=%0d errors=%0d", name, checks - c0, errors - e0);
   endtask

   initial begin
      rst_n                  = 1'b0;
      pif.pool_data_in_valid = 1'b0;
      pif.pool_data_in       = 32'h0;
      pend                   = 1'b0;
      out_idx                = 0;
      last_out               = 32'h0;
      fd_cnt                 = 0;
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(pif.pool_data_out_valid), 64'(0));
      check("rst_data", 64'(pif.pool_data_out), 64'(0));
      check("rst_frame_done", 64'(pif.frame_done), 64'(0));
      rst_n = 1'b1;

      run_frame("ramp", 0, 0);
      run_frame("peak", 1, 0);
      run_frame("edge", 2, 0);
      run_frame("random", 3, 3);

      // Gapped ramp followed by a back-to-back second frame.
      fd_cnt = 0;
      fill(0);
      build_expected();
      build_expected();
      send_frame(5, IW * IW);
      send_frame(0, IW * IW);
      flush();
      check("gapped_frame_done_count", 64'(fd_cnt), 64'(2));
      $display("frame gapped_x2 frame_done_pulses=%0d", fd_cnt);

      // Asynchronous reset mid-frame, just after a sample that produces an output.
      fill(0);
      build_expected();
      send_frame(0, 301);
      @(negedge clk);
      pif.pool_data_in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 64'(pif.pool_data_out_valid), 64'(0));
      check("midrst_data", 64'(pif.pool_data_out), 64'(0));
      check("midrst_frame_done", 64'(pif.frame_done), 64'(0));
      exp_q.delete();
      pend     = 1'b0;
      out_idx  = 0;
      last_out = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      run_frame("ramp_after_reset", 0, 0);

`ifdef POOL1_AVG_EN
      run_frame("avg_1234", 4, 0);
      run_frame("avg_all_ones", 5, 2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pool1_max.md
# pool1_max

2x2 stride-2 pooling stage placed directly downstream of the first convolution stage. Consumes the convolution's raster-order stream of post-ReLU (non-negative) sums, one sample per valid cycle. Emits one pooled sample per 2x2 window in raster order. A half-row line buffer holds horizontal-pair results between rows.

## Interface
Parameters:
- `IN_WIDTH`, 23: side length of the square input feature map, in samples (conv1 output: 27-5+1).
- `DATA_W`, 32: sample width. Unsigned; conv1 clamps negatives to 0.
- `OUT_WIDTH`, localparam = IN_WIDTH/2 (floor): output side length (11 at default).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pool_data_in` in DATA_W: input sample.
- `pool_data_in_valid` in 1: input sample valid. No backpressure; the block accepts a sample every valid cycle.
- `pool_data_out` out DATA_W: pooled sample. Reset 0.
- `pool_data_out_valid` out 1: one-cycle strobe per pooled sample. Reset 0.
- `frame_done` out 1: one-cycle pulse coincident with the last (OUT_WIDTH²-th) output of a frame. Reset 0.

## Operation
- Position counters: `col_cnt` and `row_cnt` span 0..IN_WIDTH-1. Both advance only on `pool_data_in_valid`.
  - `col_cnt` wraps at IN_WIDTH-1 and increments `row_cnt`.
  - `row_cnt` wraps at IN_WIDTH-1, so the next valid sample is (0,0) of a new frame. There is no explicit frame marker.
- Active region: `col_cnt < 2*OUT_WIDTH` and `row_cnt < 2*OUT_WIDTH`. Samples outside it (last row and last column when IN_WIDTH is odd) are counted but produce no buffer write and no output.
- Even column in active region: latch the sample into `h_reg`.
- Odd column in active region: `h = max(h_reg, in)` (unsigned compare).
  - Even row: `lbuf[col_cnt>>1] <= h`.
  - Odd row: `pool_data_out <= max(lbuf[col_cnt>>1], h)`; `pool_data_out_valid <= 1`.
- `lbuf` has OUT_WIDTH entries × DATA_W. It is register-based; no reset is required on its contents.
- Output counter: 0..OUT_WIDTH²-1, incremented per output. On the final output, assert `frame_done` and wrap the counter to 0.
- `pool_data_out` holds its last value while `pool_data_out_valid` is low.
- Gaps in `pool_data_in_valid` of any length anywhere do not change results.
- Reset mid-frame clears all counters, `h_reg`, and the outputs. The next valid sample is treated as (0,0).

## Timing
- Latency: exactly 1 clk from the valid input cycle of the window's bottom-right sample (odd row, odd column) to `pool_data_out_valid`.
- Output rate: at most one output per 2 valid input cycles. At default parameters, 121 outputs per 529 input samples.
- First output of a frame follows input sample index IN_WIDTH+1, i.e. sample (1,1), which is index 24 at default.
- `frame_done` rises in the same cycle as the 121st `pool_data_out_valid` and is never high in any other cycle.

## Configuration
- `POOL1_AVG_EN` defined: average pooling.
  - The even-row `lbuf` write stores the pair sum at DATA_W+1 bits; `h` is the pair sum.
  - Output = (lbuf + h) >> 2, computed at DATA_W+2 bits and truncated to DATA_W. Rounding is truncation.
  - Timing and valid behaviour are unchanged.
- Undefined (default): max pooling as specified above.

## Test plan
- Ramp: input value = row*23+col over a full 23x23 frame, continuous valid.
  - Output (r,c) = (2r+1)*23+2c+1.
  - First output is 24, one cycle after input (1,1).
  - 121 outputs; `frame_done` coincides with the last output, value 23*21+21 = 504.
- Single peak: all 0 except input (3,4) = 1000.
  - Output index 13, at (1,2), = 1000; all other 120 outputs = 0.
- Dropped edge: row 22 and column 22 = 0xFFFF_FFFF, rest 0.
  - All 121 outputs = 0; no output generated during row 22.
- Gapped valid: the ramp frame with random 0–5-cycle valid gaps, followed by a second back-to-back frame.
  - Outputs are identical to the ramp case in both frames.
  - `frame_done` pulses exactly twice.
- Reset mid-frame: assert `rst_n` low after input 300.
  - Outputs, `pool_data_out_valid`, and `frame_done` are 0 immediately.
  - A following full ramp frame reproduces the ramp results exactly.
- With `POOL1_AVG_EN`: window values {1,2,3,4} -> 2; window values all 0xFFFF_FFFF -> 0xFFFF_FFFF (no overflow).
